// File: rtl/conv_pkg.sv
// Shared types and dimensions for the convolution output path.
// RMW_GAP lives here so the accumulator pipeline depth is defined once.
package conv_pkg;

    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned PASS_W  = 8;
    localparam int unsigned RMW_GAP = 4;

    // Encodings kept as plain constants so legacy code can still compare against them.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        DRAIN = S_DRAIN,
        DONE  = S_DONE
    } sched_state_t;

endpackage

// File: rtl/output_accum_scheduler_if.sv
// Control, partial-sum stream and accumulator issue signals of the scheduler.
interface output_accum_scheduler_if;
    import conv_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] cfg_pixels;
    logic [PASS_W-1:0] cfg_passes;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              acc_valid;
    logic [ADDR_W-1:0] acc_address;
    logic [DATA_W-1:0] acc_data;
    logic              acc_first;
    logic              busy;
    logic              done;

    modport master (
        output start, cfg_pixels, cfg_passes, in_valid, in_data,
        input  in_ready, acc_valid, acc_address, acc_data, acc_first, busy, done
    );

    modport slave (
        input  start, cfg_pixels, cfg_passes, in_valid, in_data,
        output in_ready, acc_valid, acc_address, acc_data, acc_first, busy, done
    );

endinterface

// File: rtl/accum_hazard_window.sv
// Shift register of recently issued accumulator addresses; flags a probe that
// would land inside the read-modify-write window of an earlier issue.
module accum_hazard_window #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [ADDR_W-1:0] probe_addr_i,
    output logic              hit_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];

    // Entries age every cycle; an idle cycle shifts in an invalid slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
            vld_q[0]  <= push_i;
            addr_q[0] <= push_addr_i;
        end
    end

    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == probe_addr_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_accum_scheduler.sv
// Sequences partial sums into the output accumulator across all input-channel
// passes, marking first-pass writes and stalling on read-modify-write hazards.
module output_accum_scheduler
    import conv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    output_accum_scheduler_if.slave bus
);

    localparam int unsigned DRAIN_W = $clog2(RMW_GAP + 1);

    sched_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0]  pix_last_q, pix_last_d;
    logic [PASS_W-1:0]  pass_q, pass_d;
    logic [PASS_W-1:0]  pass_last_q, pass_last_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               acc_valid_q, acc_valid_d;
    logic               acc_first_q, acc_first_d;
    logic [ADDR_W-1:0]  acc_addr_q, acc_addr_d;
    logic [DATA_W-1:0]  acc_data_q, acc_data_d;
    logic               hit;
    logic               ready;
    logic               xfer;

    accum_hazard_window #(
        .DEPTH  (RMW_GAP - 1),
        .ADDR_W (ADDR_W)
    ) u_window (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (xfer),
        .push_addr_i  (pix_q),
        .probe_addr_i (pix_q),
        .hit_o        (hit)
    );

    // Ready depends only on registered state, never on in_valid.
    assign ready = (state_q == RUN) && !hit;
    assign xfer  = ready && bus.in_valid;

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        pix_last_d  = pix_last_q;
        pass_d      = pass_q;
        pass_last_d = pass_last_q;
        drain_d     = drain_q;
        acc_valid_d = xfer;
        acc_first_d = acc_first_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;

        if (xfer) begin
            acc_addr_d  = pix_q;
            acc_data_d  = bus.in_data;
            acc_first_d = (pass_q == '0);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // cfg_pixels of 0 wraps to all-ones, i.e. 2^ADDR_W pixels.
                    pix_last_d  = bus.cfg_pixels - ADDR_W'(1);
                    pass_last_d = (bus.cfg_passes == '0) ? '0 : bus.cfg_passes - PASS_W'(1);
                    pix_d       = '0;
                    pass_d      = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (pix_q == pix_last_q) begin
                        pix_d = '0;
                        if (pass_q == pass_last_q) begin
                            state_d = DRAIN;
                            drain_d = '0;
                        end else begin
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        pix_d = pix_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(RMW_GAP)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            pix_last_q  <= '0;
            pass_q      <= '0;
            pass_last_q <= '0;
            drain_q     <= '0;
            acc_valid_q <= 1'b0;
            acc_first_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            pix_last_q  <= pix_last_d;
            pass_q      <= pass_d;
            pass_last_q <= pass_last_d;
            drain_q     <= drain_d;
            acc_valid_q <= acc_valid_d;
            acc_first_q <= acc_first_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.acc_valid   = acc_valid_q;
    assign bus.acc_address = acc_addr_q;
    assign bus.acc_data    = acc_data_q;
    assign bus.acc_first   = acc_first_q;
    assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_output_accum_scheduler.sv
// Directed bench for output_accum_scheduler with an issue scoreboard.
module tb_output_accum_scheduler;
    import conv_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              first;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_accum_scheduler_if bus ();

    output_accum_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   issued = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   first_acc_cyc = -1;
    int   last_acc_cyc = 0;
    logic busy_at_done = 1'b0;
    int   last_issue [int];
    int   last_xfer [int];
    exp_t sb [$];
    int   model_pix, model_pass, sent, m_pixels;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score whatever the DUT presents.
    task automatic tick();
        exp_t e;
        int   a;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.acc_valid === 1'b1) begin
            issued++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            if (sb.size() == 0) begin
                chk("acc_valid_unexpected", 32'(bus.acc_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("acc_address", 32'(bus.acc_address), 32'(e.addr));
                chk("acc_data", 32'(bus.acc_data), 32'(e.data));
                chk("acc_first", 32'(bus.acc_first), 32'(e.first));
            end
            a = int'(bus.acc_address);
            if (last_issue.exists(a))
                chk("addr_spacing", 32'((cyc - last_issue[a]) >= int'(RMW_GAP)), 32'd1);
            last_issue[a] = cyc;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = bus.busy;
        end
    endtask

    task automatic drive(input logic v);
        logic exp_ready;
        int   a;
        a = model_pix;
        bus.in_valid = v;
        bus.in_data  = DATA_W'($urandom);
        exp_ready = !(last_xfer.exists(a) && ((cyc - last_xfer[a]) < int'(RMW_GAP)));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (v && bus.in_ready) begin
            sb.push_back('{addr: ADDR_W'(a), data: bus.in_data, first: (model_pass == 0)});
            last_xfer[a] = cyc;
            sent++;
            if (model_pix == m_pixels - 1) begin
                model_pix = 0;
                model_pass++;
            end else begin
                model_pix++;
            end
        end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({t, "_acc_valid"}, 32'(bus.acc_valid), 32'd0);
        chk({t, "_acc_first"}, 32'(bus.acc_first), 32'd0);
        chk({t, "_busy"}, 32'(bus.busy), 32'd0);
        chk({t, "_done"}, 32'(bus.done), 32'd0);
        chk({t, "_acc_address"}, 32'(bus.acc_address), 32'd0);
        chk({t, "_acc_data"}, 32'(bus.acc_data), 32'd0);
    endtask

    task automatic run_layer(input int pix, input int passes, input int duty,
                             input bit poke, output int span);
        int npass, total, n, d0, i0;
        npass = (passes == 0) ? 1 : passes;
        total = pix * npass;
        d0 = done_cnt;
        i0 = issued;
        model_pix = 0; model_pass = 0; sent = 0; m_pixels = pix;
        last_xfer.delete();
        last_issue.delete();
        first_acc_cyc = -1;
        bus.cfg_pixels = ADDR_W'(pix);
        bus.cfg_passes = PASS_W'(passes);
        bus.in_valid   = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        n = 0;
        while (sent < total && n < 2000) begin
            if (poke && n == 3) begin
                bus.start      = 1'b1;
                bus.cfg_pixels = ADDR_W'(1);
                bus.cfg_passes = PASS_W'(9);
            end else begin
                bus.start = 1'b0;
            end
            drive($urandom_range(99) < duty);
            tick();
            n++;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        chk("all_sent", 32'(sent), 32'(total));
        n = 0;
        while (done_cnt == d0 && n < 40) begin
            bus.start = poke && (n == 1);
            tick();
            n++;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("done_latency", 32'(done_cyc - last_acc_cyc), 32'(RMW_GAP + 1));
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        chk("issue_count", 32'(issued - i0), 32'(total));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_ready", 32'(bus.in_ready), 32'd0);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        span = last_acc_cyc - first_acc_cyc;
    endtask

    initial begin
        int span, n, i0;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.cfg_pixels = '0;
        bus.cfg_passes = '0;

        tick();
        tick();
        chk_reset("por");
        rst_n = 1'b1;
        tick();

        run_layer(8, 3, 100, 1'b0, span);
        chk("span_8x3_no_stall", 32'(span), 32'd23);

        run_layer(2, 3, 100, 1'b0, span);
        chk("span_2x3_stalled", 32'(span), 32'd9);

        run_layer(1, 4, 100, 1'b0, span);
        chk("span_1x4_every4", 32'(span), 32'd12);

        run_layer(16, 2, 50, 1'b0, span);

        // Reset in the middle of a run.
        i0 = issued;
        bus.cfg_pixels = ADDR_W'(8);
        bus.cfg_passes = PASS_W'(2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_pix = 0; model_pass = 0; sent = 0; m_pixels = 8;
        last_xfer.delete();
        last_issue.delete();
        n = 0;
        while (issued - i0 < 5 && n < 50) begin
            drive(1'b1);
            tick();
            n++;
        end
        chk("issued_before_reset", 32'(issued - i0), 32'd5);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        tick();
        chk_reset("held_reset");
        rst_n = 1'b1;
        sb.delete();
        tick();

        run_layer(8, 1, 100, 1'b0, span);
        run_layer(4, 0, 100, 1'b1, span);
        chk("span_4x0_as_one_pass", 32'(span), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_accum_scheduler.md
# output_accum_scheduler

Sequences the convolution core's partial-sum stream into the output accumulator (the read-modify-write `img_y` path) across all input-channel passes of one layer. It generates the pixel address, marks the first pass so the accumulator overwrites instead of adding, and stalls the stream when a new issue would hit an address still in the accumulator's 4-cycle read-modify-write window. It sits between the conv core output and the output data controller, and signals layer completion once the last write has landed.

## Interface
- `ADDR_W`, 13: pixel address width, matching the `img_y` depth.
- `DATA_W`, 24: partial-sum width.
- `PASS_W`, 8: pass-count width.
- `RMW_GAP`, 4: minimum cycles between two issues to the same address.
- `clk  in  1`: single clock; all flops are on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse; accepted only in IDLE.
- `cfg_pixels  in  ADDR_W`: pixels per pass, 1..2^ADDR_W. A value of 0 is treated as 2^ADDR_W.
- `cfg_passes  in  PASS_W`: number of passes, 1..255. A value of 0 is treated as 1.
- `in_valid  in  1`, `in_data  in  DATA_W`, `in_ready  out  1`: partial-sum stream. A transfer occurs when `in_valid & in_ready`.
- `acc_valid  out  1`, `acc_address  out  ADDR_W`, `acc_data  out  DATA_W`, `acc_first  out  1`: accumulator issue port.
- `busy  out  1`: high from the cycle after `start` until `done`.
- `done  out  1`: one-cycle completion pulse.

## Operation
- Reset values: state IDLE; `in_ready`, `acc_valid`, `acc_first`, `busy`, `done` = 0; `acc_address`, `acc_data` = 0; all counters = 0; hazard window entries invalid.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on `start`: latch `cfg_pixels` and `cfg_passes`; set pixel index = 0 and pass index = 0.
- RUN transfers:
  - On each transfer, register `acc_address` = pixel index, `acc_data` = `in_data`, `acc_first` = (pass index == 0), and `acc_valid` = 1 for exactly one cycle.
  - Pixel index increments on each transfer. It wraps to 0 after `cfg_pixels-1`, and the pass index increments at the wrap.
- RUN to DRAIN on the transfer of the last pixel of the last pass.
- DRAIN holds for `RMW_GAP` cycles after the final `acc_valid`, then moves to DONE.
- DONE pulses `done` for one cycle and returns to IDLE. `busy` drops in the same cycle.
- Hazard rule:
  - The last `RMW_GAP-1` issued addresses are held with valid bits.
  - `in_ready` = RUN & !(current pixel index matches any valid entry).
  - Entries age by one each cycle, whether or not a transfer occurs.
  - Only small `cfg_pixels` (< `RMW_GAP`) can trigger a stall, at the pass wrap.
- `start` in any state other than IDLE is ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partially written accumulator contents are undefined, and software restarts the layer.
- `in_data` passes through unmodified; no arithmetic is done here. Summation belongs to the accumulator.

## Timing
- `in_ready` is combinational from registered state only. It never depends on `in_valid`, so no combinational loop forms with the producer.
- Latency: transfer in cycle T gives `acc_valid` in cycle T+1.
- Throughput: 1 transfer per cycle when `cfg_pixels` >= `RMW_GAP`.
- Same-address spacing is at least `RMW_GAP` cycles at `acc_valid`.
- Completion: `done` asserts exactly `RMW_GAP`+1 cycles after the last `acc_valid`.
- The `in_valid` deassert/reassert pattern is arbitrary; the pixel index advances only on a transfer.

## Structure
- Shared package `conv_pkg` holds:
  - the `sched_state_t` enum {IDLE, RUN, DRAIN, DONE};
  - the widths `ADDR_W`, `DATA_W`, `PASS_W`;
  - `RMW_GAP`, shared with the output data controller so the pipeline depth is defined once.
- One sub-module, `accum_hazard_window`:
  - a shift register of `RMW_GAP-1` {valid, address} entries;
  - inputs: push, push address, probe address;
  - output: hit.
- The scheduler top contains the FSM, counters and output registers.

## Test plan
- `cfg_pixels`=8, `cfg_passes`=3, `in_valid` held high:
  - 24 `acc_valid` pulses, addresses 0..7 repeating;
  - `acc_first`=1 on the first 8 only;
  - no stalls;
  - `done` 5 cycles after the last issue.
- `cfg_pixels`=2, `cfg_passes`=3, `in_valid` held high: `in_ready` drops so each address is reissued at most every 4 cycles; 6 issues total; no address spacing < 4.
- `cfg_pixels`=1, `cfg_passes`=4: issues at cycles T, T+4, T+8, T+12; `acc_first` high only on the first.
- Random `in_valid` gaps (50% duty), `cfg_pixels`=16, `cfg_passes`=2: the address sequence is identical to the gap-free run and the data order is preserved.
- `rst_n` pulsed low mid-RUN (after 5 issues):
  - all outputs at reset values the same cycle;
  - `start` afterwards begins again at address 0 with `acc_first`=1.
- `start` pulsed during RUN and DRAIN: ignored; a single `done`; `cfg_passes`=0 behaves as 1.
